input_debouncer: RTL and testbench
==================================

# input_debouncer

Multi-channel switch/button debouncer that turns raw, bouncing, asynchronous board inputs into clean levels and single-cycle edge pulses. It sits directly upstream of the combinational gating stage. Its `a_out[2:0]` drive that stage's `a1`, `a2` and `a3` inputs, so every downstream AND term sees glitch-free levels. Each channel is an independent counter-qualified state machine.

## Interface
- `WIDTH`, default 3: number of independent input channels.
- `CNT_MAX`, default 1_000_000: consecutive differing samples required to accept a new level (10 ms at 100 MHz). Legal range is ≥ 1.
- `CNT_W`, default `$clog2(CNT_MAX+1)`: counter width. Derived; never overridden.

Ports:
- `clk`  in  1  system clock. All state changes on its rising edge.
- `reset`  in  1  reset; asynchronous, active-high.
- `sw_in`  in  WIDTH  raw switch/button levels, asynchronous to `clk`.
- `a_out`  out  WIDTH  debounced levels, registered. Feeds `a1..a3` downstream.
- `rise_pulse`  out  WIDTH  one-cycle pulse when `a_out[i]` goes 0→1.
- `fall_pulse`  out  WIDTH  one-cycle pulse when `a_out[i]` goes 1→0.

## Operation
- **Sampled input `s[i]`:** the synchronizer output (see Configuration), or `sw_in[i]` registered directly by the FSM.
- **Per-channel state:** `a_out[i]` and counter `cnt[i]`. They form four states:
  - STABLE_LO: `a_out=0`, `cnt=0`.
  - WAIT_HI: `a_out=0`, `cnt>0`.
  - STABLE_HI: `a_out=1`, `cnt=0`.
  - WAIT_LO: `a_out=1`, `cnt>0`.
- **Each edge, per channel:**
  - If `s[i]==a_out[i]`: `cnt[i]<=0`. Any bounce back aborts WAIT_* and returns to STABLE_*.
  - Else if `cnt[i]==CNT_MAX-1`: `a_out[i]<=s[i]` and `cnt[i]<=0`. Assert `rise_pulse[i]` if `s[i]=1`, or `fall_pulse[i]` if `s[i]=0`, for exactly that one cycle.
  - Else: `cnt[i]<=cnt[i]+1`.
- **Pulses:** registered, asserted in the same cycle `a_out` changes, deasserted the next cycle. `rise_pulse[i]` and `fall_pulse[i]` are never both high.
- **Counter range:** never exceeds `CNT_MAX-1`; no wrap-around is possible.
- **`CNT_MAX=1`:** the block degenerates to a plain register plus edge detector.
- **Channels:** fully independent. Simultaneous changes on several channels are each counted separately.
- **Reset values (immediate, asynchronous):** `a_out=0`, `rise_pulse=0`, `fall_pulse=0`, all `cnt=0`, all synchronizer flops 0. Reset mid-count discards progress.
- **No pulse on reset:** the transition from reset to the first `a_out` value emits no pulse. `a_out` was already 0, and a 0→1 after reset is a normal rise and pulses normally.

## Timing
- Input latency: `sw_in` held at a new value is first seen by the FSM at edge 1 without sync, or edge 3 with sync.
- Acceptance: `a_out` changes at edge `CNT_MAX` (no sync) or `CNT_MAX+2` (sync), counted from the first edge after the `sw_in` change.
- Pulse: coincident with that `a_out` change; width exactly 1 cycle.
- A bounce shorter than `CNT_MAX` cycles never reaches `a_out`. A bounce restarts the full latency measured from the last transition.
- After reset deasserts, the first `a_out` change occurs no earlier than `CNT_MAX` (+2 with sync) edges later.
- Throughput: at most one `a_out` transition per channel per `CNT_MAX` cycles.

## Configuration
- `DEBOUNCE_SYNC_EN` defined: a 2-flop synchronizer per channel, reset to 0, sits in front of the FSM. Total latency is `CNT_MAX+2`. This is required for real pins.
- Not defined: the FSM samples `sw_in` directly. Total latency is `CNT_MAX`. Use only for inputs already synchronous to `clk`.

## Test plan
All scenarios use `WIDTH=3`, `CNT_MAX=8`, and `DEBOUNCE_SYNC_EN` defined unless noted.
- **Reset:** assert `reset` mid-cycle with `sw_in=111` → `a_out=000` and pulses `000` immediately. After release, `a_out=111` with `rise_pulse=111` at edge 10, and `rise_pulse=000` at edge 11.
- **Bounce:** `sw_in[0]` 0→1 for 5 cycles, 0 for 1 cycle, then 1 steady → `a_out[0]` stays 0 throughout the bounce. It rises at edge 10 after the final 0→1. `rise_pulse[0]` fires once.
- **Release:** `sw_in[0]` 1→0 held → `a_out[0]` falls at edge 10. `fall_pulse[0]` is high one cycle; `rise_pulse` stays 0.
- **Independent channels:** `sw_in[1]` and `sw_in[2]` both go 0→1 at the same edge; `sw_in[2]` dips to 0 for one cycle at edge 4 → `a_out[1]` rises at edge 10. `a_out[2]` rises 10 edges after its re-rise. `a_out[0]` is unaffected.
- **Reset mid-count:** assert `reset` when `cnt[0]=5` → `a_out[0]=0` immediately, with no pulse. After release, a full 10-edge wait is needed.
- **`DEBOUNCE_SYNC_EN` undefined:** a steady 0→1 on `sw_in[2]` → `a_out[2]` and `rise_pulse[2]` at edge 8.

Source files
------------

// File: rtl/input_debouncer_if.sv
// Debouncer signal bundle: raw switch levels in, clean levels and edge pulses out.
interface input_debouncer_if #(
    parameter int unsigned WIDTH = 3
) ();
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;

    // Board / stimulus side drives raw levels and observes clean outputs.
    modport master (
        output sw_in,
        input  a_out,
        input  rise_pulse,
        input  fall_pulse
    );

    // Debouncer side.
    modport slave (
        input  sw_in,
        output a_out,
        output rise_pulse,
        output fall_pulse
    );
endinterface

// File: rtl/input_debouncer.sv
// Multi-channel counter-qualified switch debouncer with registered levels and
// single-cycle rise/fall pulses. Each channel runs its own 4-state FSM.
// Optional macro DEBOUNCE_SYNC_EN: inserts a 2-flop synchronizer per channel
// ahead of the FSM (adds 2 cycles of latency); required for real board pins.
module input_debouncer #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned CNT_MAX = 1_000_000,
    parameter int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input_debouncer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic [WIDTH-1:0] s_c;
    logic [WIDTH-1:0] level_c;
    state_t           state [WIDTH];
    logic [CNT_W-1:0] cnt   [WIDTH];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

`ifdef DEBOUNCE_SYNC_EN
    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;

    // Two-flop synchronizer bringing asynchronous pins into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= bus.sw_in;
            sync_q2 <= sync_q1;
        end
    end

    assign s_c = sync_q2;
`else
    assign s_c = bus.sw_in;
`endif

    // Currently accepted level of each channel, decoded from its FSM state.
    always_comb begin
        level_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            level_c[i] = (state[i] == STABLE_HI) || (state[i] == WAIT_LO);
        end
    end

    // Per-channel debounce FSM: count consecutive differing samples, accept on the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= STABLE_LO;
                cnt[i]   <= '0;
            end
            a_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                rise_q[i] <= 1'b0;
                fall_q[i] <= 1'b0;
                if (s_c[i] == level_c[i]) begin
                    // Matching sample (or a bounce back) abandons any pending change.
                    cnt[i]   <= '0;
                    state[i] <= level_c[i] ? STABLE_HI : STABLE_LO;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]    <= '0;
                    a_q[i]    <= s_c[i];
                    state[i]  <= s_c[i] ? STABLE_HI : STABLE_LO;
                    rise_q[i] <= s_c[i];
                    fall_q[i] <= ~s_c[i];
                end else begin
                    cnt[i]   <= cnt[i] + CNT_W'(1);
                    state[i] <= level_c[i] ? WAIT_LO : WAIT_HI;
                end
            end
        end
    end

    assign bus.a_out      = a_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (WIDTH=3, CNT_MAX=8): expected per-edge
// output snapshots are queued when stimulus is applied and compared as edges pass.
module tb_input_debouncer;

    localparam int unsigned WIDTH   = 3;
    localparam int unsigned CNT_MAX = 8;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = CNT_MAX + 2;
`else
    localparam int LAT = CNT_MAX;
`endif

    typedef struct {
        int          edge_no;
        logic [2:0]  a;
        logic [2:0]  r;
        logic [2:0]  f;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    exp_t sb [$];

    input_debouncer_if #(.WIDTH(WIDTH)) bus ();

    input_debouncer #(
        .WIDTH   (WIDTH),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_exp(input int k, input logic [2:0] a,
                                     input logic [2:0] r, input logic [2:0] f);
        exp_t e;
        e.edge_no = k;
        e.a       = a;
        e.r       = r;
        e.f       = f;
        sb.push_back(e);
    endfunction

    // Power-on reset, reset release with inputs high, and asynchronous mid-cycle reset.
    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        bus.sw_in = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_state a_out=%b rise=%b fall=%b expected all 000",
                     bus.a_out, bus.rise_pulse, bus.fall_pulse);
        end
        reset = 1'b0;
        bus.sw_in = 3'b111;
        for (int k = 1; k <= LAT + 1; k++)
            push_exp(k, (k >= LAT) ? 3'b111 : 3'b000, (k == LAT) ? 3'b111 : 3'b000, 3'b000);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_no == k) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== {e.a, e.r, e.f}) begin
                    n_bad++;
                    $display("FAIL reset_first_rise edge %0d: a_out=%b exp %b rise=%b exp %b fall=%b exp %b",
                             k, bus.a_out, e.a, bus.rise_pulse, e.r, bus.fall_pulse, e.f);
                end
            end
        end
        // Mid-cycle assertion with inputs still high must clear outputs without a clock.
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_async a_out=%b rise=%b fall=%b expected all 000",
                     bus.a_out, bus.rise_pulse, bus.fall_pulse);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= LAT + 1; k++)
            push_exp(k, (k >= LAT) ? 3'b111 : 3'b000, (k == LAT) ? 3'b111 : 3'b000, 3'b000);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_no == k) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== {e.a, e.r, e.f}) begin
                    n_bad++;
                    $display("FAIL reset_rerelease edge %0d: a_out=%b exp %b rise=%b exp %b fall=%b exp %b",
                             k, bus.a_out, e.a, bus.rise_pulse, e.r, bus.fall_pulse, e.f);
                end
            end
        end
    endtask

    // Channel 0 released: one fall pulse at the latency edge, no rise pulse.
    task automatic test_release();
        exp_t e;
        bus.sw_in = 3'b110;
        for (int k = 1; k <= LAT + 1; k++)
            push_exp(k, (k >= LAT) ? 3'b110 : 3'b111, 3'b000, (k == LAT) ? 3'b001 : 3'b000);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_no == k) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== {e.a, e.r, e.f}) begin
                    n_bad++;
                    $display("FAIL release edge %0d: a_out=%b exp %b rise=%b exp %b fall=%b exp %b",
                             k, bus.a_out, e.a, bus.rise_pulse, e.r, bus.fall_pulse, e.f);
                end
            end
        end
    endtask

    // Channel 0 high 5 cycles, low 1, then high: only the final rise is accepted.
    task automatic test_bounce();
        exp_t e;
        bus.sw_in = 3'b111;
        for (int k = 1; k <= LAT + 7; k++)
            push_exp(k, (k >= LAT + 6) ? 3'b111 : 3'b110,
                     (k == LAT + 6) ? 3'b001 : 3'b000, 3'b000);
        for (int k = 1; k <= LAT + 7; k++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_no == k) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== {e.a, e.r, e.f}) begin
                    n_bad++;
                    $display("FAIL bounce edge %0d: a_out=%b exp %b rise=%b exp %b fall=%b exp %b",
                             k, bus.a_out, e.a, bus.rise_pulse, e.r, bus.fall_pulse, e.f);
                end
            end
            if (k == 5) bus.sw_in = 3'b110;
            if (k == 6) bus.sw_in = 3'b111;
        end
    endtask

    // Channels 1 and 2 rise together; channel 2 dips at edge 4 and restarts its count.
    task automatic test_independent();
        exp_t e;
        bus.sw_in = 3'b001;
        for (int k = 1; k <= LAT + 1; k++)
            push_exp(k, (k >= LAT) ? 3'b001 : 3'b111, 3'b000, (k == LAT) ? 3'b110 : 3'b000);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_no == k) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== {e.a, e.r, e.f}) begin
                    n_bad++;
                    $display("FAIL indep_fall edge %0d: a_out=%b exp %b rise=%b exp %b fall=%b exp %b",
                             k, bus.a_out, e.a, bus.rise_pulse, e.r, bus.fall_pulse, e.f);
                end
            end
        end
        bus.sw_in = 3'b111;
        for (int k = 1; k <= LAT + 5; k++)
            push_exp(k, 3'b001 | ((k >= LAT) ? 3'b010 : 3'b000) | ((k >= LAT + 4) ? 3'b100 : 3'b000),
                     ((k == LAT) ? 3'b010 : 3'b000) | ((k == LAT + 4) ? 3'b100 : 3'b000), 3'b000);
        for (int k = 1; k <= LAT + 5; k++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_no == k) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== {e.a, e.r, e.f}) begin
                    n_bad++;
                    $display("FAIL indep_rise edge %0d: a_out=%b exp %b rise=%b exp %b fall=%b exp %b",
                             k, bus.a_out, e.a, bus.rise_pulse, e.r, bus.fall_pulse, e.f);
                end
            end
            if (k == 3) bus.sw_in = 3'b011;
            if (k == 4) bus.sw_in = 3'b111;
        end
    endtask

    // Reset while channel 0 has counted to 5: progress lost, no pulse, full wait again.
    task automatic test_reset_mid_count();
        exp_t e;
        bus.sw_in = 3'b000;
        for (int k = 1; k <= LAT + 1; k++)
            push_exp(k, (k >= LAT) ? 3'b000 : 3'b111, 3'b000, (k == LAT) ? 3'b111 : 3'b000);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_no == k) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== {e.a, e.r, e.f}) begin
                    n_bad++;
                    $display("FAIL midcnt_prep edge %0d: a_out=%b exp %b rise=%b exp %b fall=%b exp %b",
                             k, bus.a_out, e.a, bus.rise_pulse, e.r, bus.fall_pulse, e.f);
                end
            end
        end
        bus.sw_in = 3'b001;
        // Edge at which the channel-0 counter reaches 5.
        repeat (LAT - int'(CNT_MAX) + 5) @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== 9'b0) begin
            n_bad++;
            $display("FAIL midcnt_reset a_out=%b rise=%b fall=%b expected all 000",
                     bus.a_out, bus.rise_pulse, bus.fall_pulse);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= LAT + 1; k++)
            push_exp(k, (k >= LAT) ? 3'b001 : 3'b000, (k == LAT) ? 3'b001 : 3'b000, 3'b000);
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].edge_no == k) begin
                e = sb.pop_front();
                n_cmp++;
                if ({bus.a_out, bus.rise_pulse, bus.fall_pulse} !== {e.a, e.r, e.f}) begin
                    n_bad++;
                    $display("FAIL midcnt_rewait edge %0d: a_out=%b exp %b rise=%b exp %b fall=%b exp %b",
                             k, bus.a_out, e.a, bus.rise_pulse, e.r, bus.fall_pulse, e.f);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.sw_in = 3'b000;
        test_reset();
        test_release();
        test_bounce();
        test_independent();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout: compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
